// File: rtl/alu_pkg.sv
// alu_pkg: shared width, divider state encoding and divide-by-zero quotient
package alu_pkg;
  localparam int WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;
  localparam logic [WIDTH-1:0] DIV0_Q = '1;
endpackage

// File: rtl/subtractor.sv
// subtractor: unsigned N-bit subtract with borrow-out, BO=1 when A<B
module subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] DIFF,
  output logic         BO
);
  assign {BO, DIFF} = {1'b0, A} - {1'b0, B};
endmodule

// File: rtl/divider.sv
// divider: iterative restoring unsigned divider with START/BUSY/DONE handshake
module divider
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] DIVIDEND,
  input  logic [W-1:0] DIVISOR,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] QUOTIENT,
  output logic [W-1:0] REMAINDER,
  output logic         DIV0
);
  localparam int CW = $clog2(W + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [W:0] r, t, diff;
  logic [W-1:0] q, d;
  logic bo;
  logic zero_in;
  assign zero_in = DIVISOR == '0;
  assign t = (W + 1)'({r, q[W-1]});
  assign BUSY = state != IDLE;
  subtractor #(.N(W + 1)) u_sub (
    .A(t),
    .B({1'b0, d}),
    .DIFF(diff),
    .BO(bo)
  );
  always_comb begin
    state_n = state == IDLE ? (START ? (zero_in ? FINISH : RUN) : IDLE) :
              state == RUN  ? (cnt == CW'(1) ? FINISH : RUN) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      DONE <= 1'b0;
      QUOTIENT <= '0;
      REMAINDER <= '0;
      DIV0 <= 1'b0;
    end else begin
      DONE <= state == FINISH;
      if (state == IDLE && START) begin
        d <= DIVISOR;
        q <= zero_in ? W'(DIV0_Q) : DIVIDEND;
        r <= zero_in ? {1'b0, DIVIDEND} : '0;
        cnt <= CW'(W);
      end
      if (state == RUN) begin
        r <= bo ? t : diff;
        q <= {q[W-2:0], ~bo};
        cnt <= cnt - CW'(1);
      end
      if (state == FINISH) begin
        QUOTIENT <= q;
        REMAINDER <= W'(r);
        DIV0 <= d == '0;
      end
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed self-checking bench for divider
module tb_divider;
  logic clk = 1'b0;
  logic rst, start, busy, done, div0;
  logic [7:0] dividend, divisor, quotient, remainder;
  int checks = 0;
  int errors = 0;
  int lat, bcy, seen;
  always #5 clk = ~clk;
  divider dut (
    .CLK(clk),
    .RST(rst),
    .START(start),
    .DIVIDEND(dividend),
    .DIVISOR(divisor),
    .BUSY(busy),
    .DONE(done),
    .QUOTIENT(quotient),
    .REMAINDER(remainder),
    .DIV0(div0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dividend = 8'hxx;
    divisor = 8'hxx;
  endtask
  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (!done && l < 20) begin
      b += int'(busy);
      @(negedge clk);
      l++;
    end
    check("done_seen", 32'(done), 1);
  endtask
  task automatic result(input string tag, input logic [7:0] q, input logic [7:0] r, input logic z);
    check({tag, "_q"}, 32'(quotient), 32'(q));
    check({tag, "_r"}, 32'(remainder), 32'(r));
    check({tag, "_div0"}, 32'(div0), 32'(z));
    check({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask
  task automatic zeros(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_q"}, 32'(quotient), 0);
    check({tag, "_r"}, 32'(remainder), 0);
    check({tag, "_div0"}, 32'(div0), 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    zeros("reset");
    rst = 1'b0;
    @(negedge clk);
    start_op(8'd100, 8'd7);
    wait_done(lat, bcy);
    check("lat_100_7", 32'(lat), 9);
    check("busy_100_7", 32'(bcy), 9);
    result("100_7", 8'd14, 8'd2, 1'b0);
    start_op(8'd255, 8'd1);
    wait_done(lat, bcy);
    result("255_1", 8'd255, 8'd0, 1'b0);
    start_op(8'd5, 8'd9);
    wait_done(lat, bcy);
    result("5_9", 8'd0, 8'd5, 1'b0);
    start_op(8'd255, 8'd255);
    check("b2b_done_falls", 32'(done), 0);
    check("b2b_busy", 32'(busy), 1);
    wait_done(lat, bcy);
    check("lat_b2b", 32'(lat), 9);
    result("255_255", 8'd1, 8'd0, 1'b0);
    start_op(8'd200, 8'd0);
    wait_done(lat, bcy);
    check("lat_div0", 32'(lat), 1);
    check("busy_div0", 32'(bcy), 1);
    result("200_0", 8'hFF, 8'd200, 1'b1);
    start_op(8'd9, 8'd3);
    wait_done(lat, bcy);
    result("9_3", 8'd3, 8'd0, 1'b0);
    start_op(8'd100, 8'd7);
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcy);
    check("lat_ignored", 32'(lat), 6);
    result("ignored", 8'd14, 8'd2, 1'b0);
    @(negedge clk);
    start_op(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    zeros("mid_reset");
    seen = 0;
    repeat (12) begin
      seen += int'(done);
      @(negedge clk);
    end
    check("no_done_after_reset", 32'(seen), 0);
    start_op(8'd100, 8'd7);
    wait_done(lat, bcy);
    check("lat_after_reset", 32'(lat), 9);
    result("after_reset", 8'd14, 8'd2, 1'b0);
    for (int a = 0; a < 256; a += 23) begin
      for (int b = 1; b < 256; b += 29) begin
        start_op(8'(a), 8'(b));
        wait_done(lat, bcy);
        check($sformatf("sweep_q_%0d_%0d", a, b), 32'(quotient), 32'(a / b));
        check($sformatf("sweep_r_%0d_%0d", a, b), 32'(remainder), 32'(a % b));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
